// File: rtl/timer_pkg.sv
// Shared constants for the timer / PWM dead-time slice: data widths, register
// map, CTRL bit positions and the dead-time FSM state codes.
package timer_pkg;

  // Timer constants
  localparam int TIMER_WIDTH    = 8;
  localparam int CFG_ADDR_WIDTH = 3;
  localparam int CMP_CHANNELS   = 2;

  // Register addresses
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_CTRL     = 3'd0;
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_DEADTIME = 3'd1;
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_STATUS   = 3'd2;
  localparam logic [CFG_ADDR_WIDTH-1:0] ADDR_PERIODS  = 3'd3;

  // CTRL bit indices
  localparam int CTRL_OUT_EN    = 0;
  localparam int CTRL_INVERT    = 1;
  localparam int CTRL_FAULT_CLR = 2;

  // STATUS bit positions
  localparam int STATUS_FAULT = 3;

  // FSM state codes, visible through STATUS[2:0]
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEAD_LH = 3'd1,
    ST_HIGH    = 3'd2,
    ST_DEAD_HL = 3'd3,
    ST_LOW     = 3'd4
  } pwm_state_e;

  // Dead counter load value: a zero DEADTIME still yields one both-low cycle.
  function automatic logic [TIMER_WIDTH-1:0] dead_load(input logic [TIMER_WIDTH-1:0] dt);
    dead_load = (dt == '0) ? TIMER_WIDTH'(1) : dt;
  endfunction

endpackage

// File: rtl/pwm_deadtime_if.sv
// Configuration bus of the PWM dead-time block.
//
// Bus semantics: there is no valid/ready pair. config_write_enable acts as a
// valid that is always accepted: a write takes effect at the rising clk edge
// where config_write_enable is sampled high. read_data is a purely
// combinational function of config_address and the register contents, so a
// read needs no strobe and no wait cycle.
interface pwm_deadtime_if;
  import timer_pkg::*;

  logic [CFG_ADDR_WIDTH-1:0] config_address;
  logic                      config_write_enable;
  logic [TIMER_WIDTH-1:0]    write_data;
  logic [TIMER_WIDTH-1:0]    read_data;

  modport master (
    output config_address,
    output config_write_enable,
    output write_data,
    input  read_data
  );

  modport slave (
    input  config_address,
    input  config_write_enable,
    input  write_data,
    output read_data
  );

endinterface

// File: rtl/pwm_deadtime_edge_detect.sv
// Rising-edge detector for one comparator input. The previous-sample flop only
// advances while enable is high, so detection is frozen when disabled.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic sig_in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next previous-sample: track the input only while enabled.
  always_comb begin
    prev_d = prev_q;
    if (enable) begin
      prev_d = sig_in;
    end
  end

  // Previous-sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = enable & sig_in & ~prev_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary PWM driver with dead-time insertion. One comparator edge
// starts the high side, the other starts the low side; every hand-over passes
// through a both-low interval of max(DEADTIME,1) cycles. A fault input trips
// the bridge to IDLE and latches until software clears it.
module pwm_deadtime
  import timer_pkg::*;
#(
  parameter logic [TIMER_WIDTH-1:0] DEADTIME_RST = 8'd4,
  parameter int                     SET_CH       = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  pwm_deadtime_if.slave  cfg,
  input  logic           comparator_0_in,
  input  logic           comparator_1_in,
  input  logic           fault_in,
  output logic           pwm_high,
  output logic           pwm_low
);

  // Register file
  logic                   out_en_q,   out_en_d;
  logic                   invert_q,   invert_d;
  logic [TIMER_WIDTH-1:0] deadtime_q, deadtime_d;
  logic                   fault_q,    fault_d;
  logic [TIMER_WIDTH-1:0] periods_q,  periods_d;

  // FSM and dead counter
  pwm_state_e             state_q,    state_d;
  logic [TIMER_WIDTH-1:0] cnt_q,      cnt_d;

  // Registered gate drives
  logic                   pwm_high_q, pwm_high_d;
  logic                   pwm_low_q,  pwm_low_d;

  // Edge events
  logic                   rise_0;
  logic                   rise_1;
  logic                   set_edge;
  logic                   clr_edge;

  logic [TIMER_WIDTH-1:0] rd_data;
  logic                   cfg_wr_ctrl;
  logic                   cfg_wr_dt;

  edge_detect u_edge_0 (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .sig_in (comparator_0_in),
    .rise   (rise_0)
  );

  edge_detect u_edge_1 (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .sig_in (comparator_1_in),
    .rise   (rise_1)
  );

  assign set_edge = (SET_CH == 0) ? rise_0 : rise_1;
  assign clr_edge = (SET_CH == 0) ? rise_1 : rise_0;

  assign cfg_wr_ctrl = cfg.config_write_enable && (cfg.config_address == ADDR_CTRL);
  assign cfg_wr_dt   = cfg.config_write_enable && (cfg.config_address == ADDR_DEADTIME);

  // Register writes and fault latch; FAULT_CLR is a pulse and is not stored.
  always_comb begin
    out_en_d   = out_en_q;
    invert_d   = invert_q;
    deadtime_d = deadtime_q;
    fault_d    = fault_q;
    if (cfg_wr_ctrl) begin
      out_en_d = cfg.write_data[CTRL_OUT_EN];
      invert_d = cfg.write_data[CTRL_INVERT];
      if (cfg.write_data[CTRL_FAULT_CLR] && !fault_in) begin
        fault_d = 1'b0;
      end
    end
    if (cfg_wr_dt) begin
      deadtime_d = cfg.write_data;
    end
    // An active trip always wins over a clear.
    if (fault_in) begin
      fault_d = 1'b1;
    end
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en_q   <= 1'b0;
      invert_q   <= 1'b0;
      deadtime_q <= DEADTIME_RST;
      fault_q    <= 1'b0;
    end else begin
      out_en_q   <= out_en_d;
      invert_q   <= invert_d;
      deadtime_q <= deadtime_d;
      fault_q    <= fault_d;
    end
  end

  // FSM state register, dead counter and period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      periods_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      periods_q <= periods_d;
    end
  end

  // FSM next state. Fault and a cleared OUT_EN bypass the enable hold so the
  // bridge can always be shut down; otherwise enable low freezes everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    periods_d = periods_q;
    if (fault_in || !out_en_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (!fault_q) begin
            state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          // A simultaneous CLR edge cancels the SET edge here.
          if (set_edge && !clr_edge) begin
            state_d = ST_DEAD_LH;
            cnt_d   = dead_load(deadtime_q);
          end
        end
        ST_HIGH: begin
          if (clr_edge) begin
            state_d   = ST_DEAD_HL;
            cnt_d     = dead_load(deadtime_q);
            periods_d = periods_q + TIMER_WIDTH'(1);
          end
        end
        ST_DEAD_LH: begin
          if (cnt_q <= TIMER_WIDTH'(1)) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - TIMER_WIDTH'(1);
          end
        end
        ST_DEAD_HL: begin
          if (cnt_q <= TIMER_WIDTH'(1)) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - TIMER_WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM output decode; at most one side is asserted before inversion.
  always_comb begin
    pwm_high_d = (state_q == ST_HIGH) ^ invert_q;
    pwm_low_d  = (state_q == ST_LOW)  ^ invert_q;
  end

  // Gate drive registers: outputs follow the state one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_high_q <= 1'b0;
      pwm_low_q  <= 1'b0;
    end else begin
      pwm_high_q <= pwm_high_d;
      pwm_low_q  <= pwm_low_d;
    end
  end

  assign pwm_high = pwm_high_q;
  assign pwm_low  = pwm_low_q;

  // Combinational read mux.
  always_comb begin
    rd_data = '0;
    case (cfg.config_address)
      ADDR_CTRL: begin
        rd_data[CTRL_OUT_EN] = out_en_q;
        rd_data[CTRL_INVERT] = invert_q;
      end
      ADDR_DEADTIME: rd_data = deadtime_q;
      ADDR_STATUS: begin
        rd_data[2:0]          = state_q;
        rd_data[STATUS_FAULT] = fault_q;
      end
      ADDR_PERIODS: rd_data = periods_q;
      default:      rd_data = '0;
    endcase
  end

  assign cfg.read_data = rd_data;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios followed by randomized stimulus,
// all checked cycle by cycle against a timeline model of the dead-time PWM.
module tb_pwm_deadtime;

  localparam int SET_CH = 0;
  localparam int PH_IDLE = 0, PH_DLH = 1, PH_HIGH = 2, PH_DHL = 3, PH_LOW = 4;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic comparator_0_in = 1'b0;
  logic comparator_1_in = 1'b0;
  logic fault_in = 1'b0;
  logic pwm_high;
  logic pwm_low;

  always #5 clk = ~clk;

  pwm_deadtime_if cfg_if ();

  pwm_deadtime #(
    .DEADTIME_RST (8'd4),
    .SET_CH       (SET_CH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .cfg             (cfg_if),
    .comparator_0_in (comparator_0_in),
    .comparator_1_in (comparator_1_in),
    .fault_in        (fault_in),
    .pwm_high        (pwm_high),
    .pwm_low         (pwm_low)
  );

  initial begin
    cfg_if.config_address      = 3'd0;
    cfg_if.config_write_enable = 1'b0;
    cfg_if.write_data          = 8'd0;
  end

  // Checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase plus the absolute cycle at which a dead interval ends
  int   m_cyc = 0;
  int   m_ph = PH_IDLE;
  int   m_dead_until = 0;
  int   m_dt = 4;
  int   m_per = 0;
  bit   m_oe = 0, m_inv = 0, m_flt = 0;
  bit   m_prev0 = 0, m_prev1 = 0;

  // Scoreboard: {pwm_high, pwm_low, read_data}
  logic [9:0] exp_q[$];

  task automatic model_step();
    bit eh, el, e0, e1, set_e, clr_e;
    logic [7:0] rd;
    m_cyc++;
    if (rst) begin
      m_ph = PH_IDLE; m_oe = 0; m_inv = 0; m_dt = 4; m_flt = 0; m_per = 0;
      m_prev0 = 0; m_prev1 = 0;
      eh = 0; el = 0;
    end else begin
      // Pins show the phase that held before this edge.
      eh = (m_ph == PH_HIGH) ^ m_inv;
      el = (m_ph == PH_LOW) ^ m_inv;
      e0 = enable && comparator_0_in && !m_prev0;
      e1 = enable && comparator_1_in && !m_prev1;
      if (enable) begin
        m_prev0 = comparator_0_in;
        m_prev1 = comparator_1_in;
      end
      set_e = (SET_CH == 0) ? e0 : e1;
      clr_e = (SET_CH == 0) ? e1 : e0;
      if (fault_in || !m_oe) begin
        m_ph = PH_IDLE;
      end else if (!enable) begin
        if (m_ph == PH_DLH || m_ph == PH_DHL) m_dead_until++;
      end else begin
        case (m_ph)
          PH_IDLE: if (!m_flt) m_ph = PH_LOW;
          PH_LOW: if (set_e && !clr_e) begin
            m_ph = PH_DLH;
            m_dead_until = m_cyc + ((m_dt == 0) ? 1 : m_dt);
          end
          PH_HIGH: if (clr_e) begin
            m_ph = PH_DHL;
            m_dead_until = m_cyc + ((m_dt == 0) ? 1 : m_dt);
            m_per = (m_per + 1) % 256;
          end
          PH_DLH: if (m_cyc >= m_dead_until) m_ph = PH_HIGH;
          PH_DHL: if (m_cyc >= m_dead_until) m_ph = PH_LOW;
          default: m_ph = PH_IDLE;
        endcase
      end
      if (cfg_if.config_write_enable) begin
        if (cfg_if.config_address == 3'd0) begin
          m_oe  = cfg_if.write_data[0];
          m_inv = cfg_if.write_data[1];
          if (cfg_if.write_data[2] && !fault_in) m_flt = 0;
        end else if (cfg_if.config_address == 3'd1) begin
          m_dt = int'(cfg_if.write_data);
        end
      end
      if (fault_in) m_flt = 1;
    end
    case (cfg_if.config_address)
      3'd0:    rd = {6'd0, m_inv, m_oe};
      3'd1:    rd = 8'(m_dt);
      3'd2:    rd = {4'd0, m_flt, 3'(m_ph)};
      3'd3:    rd = 8'(m_per);
      default: rd = 8'd0;
    endcase
    exp_q.push_back({eh, el, rd});
  endtask

  // Driver: stimulus levels applied on the falling edge
  logic       rst_lvl = 1, en_lvl = 1, c0_lvl = 0, c1_lvl = 0, flt_lvl = 0, we_lvl = 0;
  logic [2:0] addr_lvl = 0;
  logic [7:0] wd_lvl = 0;

  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    rst                        = rst_lvl;
    enable                     = en_lvl;
    comparator_0_in            = c0_lvl;
    comparator_1_in            = c1_lvl;
    fault_in                   = flt_lvl;
    cfg_if.config_address      = addr_lvl;
    cfg_if.config_write_enable = we_lvl;
    cfg_if.write_data          = wd_lvl;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("pwm_high", 32'(pwm_high), 32'(e[9]));
    check("pwm_low", 32'(pwm_low), 32'(e[8]));
    check("read_data", 32'(cfg_if.read_data), 32'(e[7:0]));
    we_lvl = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we_lvl   = 1;
    addr_lvl = a;
    wd_lvl   = d;
    step();
  endtask

  // Count both-low cycles until either pin rises, bounded.
  task automatic count_dead(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (pwm_high || pwm_low) break;
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // Reset state
    rst_lvl = 1; step(); step();
    rst_lvl = 0; addr_lvl = 3'd1; step();
    check("rst_deadtime", 32'(cfg_if.read_data), 32'd4);
    addr_lvl = 3'd2; step();
    check("rst_status", 32'(cfg_if.read_data), 32'd0);
    check("rst_pins", 32'({pwm_high, pwm_low}), 32'd0);

    // CTRL=1, DEADTIME=3, SET edge
    wr(3'd0, 8'h01);
    wr(3'd1, 8'd3);
    addr_lvl = 3'd2; step();
    check("low_phase", 32'(pwm_low), 32'd1);
    check("status_low", 32'(cfg_if.read_data), 32'd4);
    c0_lvl = 1; step();
    check("low_holds_at_edge", 32'(pwm_low), 32'd1);
    count_dead(n);
    check("dead_lh_3", 32'(n), 32'd3);
    check("high_rises", 32'(pwm_high), 32'd1);
    check("status_high", 32'(cfg_if.read_data), 32'd2);

    // Simultaneous SET and CLR in HIGH: CLR wins
    c0_lvl = 0; step();
    c0_lvl = 1; c1_lvl = 1; step();
    check("status_dead_hl", 32'(cfg_if.read_data), 32'd3);
    addr_lvl = 3'd3; step();
    check("periods_one", 32'(cfg_if.read_data), 32'd1);
    count_dead(n);
    check("dead_hl_rest", 32'(n), 32'd2);
    check("low_after_hl", 32'(pwm_low), 32'd1);

    // DEADTIME=0: one both-low cycle each way
    wr(3'd1, 8'd0);
    c0_lvl = 0; c1_lvl = 0; step();
    c0_lvl = 1; step();
    count_dead(n);
    check("dead_lh_min", 32'(n), 32'd1);
    check("high_min", 32'(pwm_high), 32'd1);
    c1_lvl = 1; step();
    count_dead(n);
    check("dead_hl_min", 32'(n), 32'd1);
    check("low_min", 32'(pwm_low), 32'd1);

    // Fault while HIGH
    c0_lvl = 0; step();
    c0_lvl = 1; step();
    count_dead(n);
    check("high_before_fault", 32'(pwm_high), 32'd1);
    flt_lvl = 1; addr_lvl = 3'd2; step();
    step();
    check("fault_pins", 32'({pwm_high, pwm_low}), 32'd0);
    check("status_fault", 32'(cfg_if.read_data), 32'h08);
    wr(3'd0, 8'h05);
    addr_lvl = 3'd2; step();
    check("fault_clr_ignored", 32'(cfg_if.read_data), 32'h08);
    flt_lvl = 0; step();
    check("fault_held", 32'(cfg_if.read_data), 32'h08);
    wr(3'd0, 8'h05);
    addr_lvl = 3'd2; step();
    check("fault_clr_low", 32'(cfg_if.read_data), 32'd4);
    step();
    check("low_after_clr", 32'(pwm_low), 32'd1);

    // Reset during DEAD_LH
    wr(3'd1, 8'd10);
    c0_lvl = 0; step();
    c0_lvl = 1; step();
    step(); step();
    rst_lvl = 1; addr_lvl = 3'd2; step();
    check("rst_mid_pins", 32'({pwm_high, pwm_low}), 32'd0);
    check("rst_mid_status", 32'(cfg_if.read_data), 32'd0);
    rst_lvl = 0; addr_lvl = 3'd1; step();
    check("rst_mid_deadtime", 32'(cfg_if.read_data), 32'd4);

    // Unmapped address ignores writes
    wr(3'd5, 8'hFF);
    step();
    check("addr5_ignored", 32'(cfg_if.read_data), 32'd0);

    // 256 periods: PERIODS wraps
    c0_lvl = 0; c1_lvl = 0;
    wr(3'd0, 8'h01);
    wr(3'd1, 8'd0);
    addr_lvl = 3'd3;
    for (int p = 0; p < 256; p++) begin
      c0_lvl = 1; step();
      c0_lvl = 0; step();
      c1_lvl = 1; step();
      c1_lvl = 0; step();
      if (p == 254) check("periods_255", 32'(cfg_if.read_data), 32'd255);
    end
    check("periods_wrap", 32'(cfg_if.read_data), 32'd0);
    addr_lvl = 3'd5; step();
    check("addr5_read", 32'(cfg_if.read_data), 32'd0);

    // Randomized traffic
    wr(3'd0, 8'h01);
    for (int i = 0; i < 1500; i++) begin
      rst_lvl  = ($urandom_range(0, 299) == 0);
      en_lvl   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) c0_lvl = ~c0_lvl;
      if ($urandom_range(0, 3) == 0) c1_lvl = ~c1_lvl;
      flt_lvl  = ($urandom_range(0, 79) == 0);
      addr_lvl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 14) == 0) begin
        we_lvl = 1;
        case ($urandom_range(0, 2))
          0: begin
            addr_lvl  = 3'd0;
            wd_lvl    = 8'($urandom);
            wd_lvl[0] = ($urandom_range(0, 7) != 0);
            wd_lvl[1] = ($urandom_range(0, 3) == 0);
          end
          1: begin
            addr_lvl = 3'd1;
            wd_lvl   = 8'($urandom_range(0, 6));
          end
          default: begin
            addr_lvl = 3'($urandom_range(2, 7));
            wd_lvl   = 8'($urandom);
          end
        endcase
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
